// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with its own bit timer.
// Valid/ready input, registered txd/ready/idle/done outputs.
module uart_tx_cfg #(
  parameter int CLK_DIV   = 868,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data_i,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_idle,
  output logic                 tx_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("uart_tx_cfg: CLK_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] dat_q, dat_d;
  logic                 txd_q, txd_d;
  logic                 ready_q, ready_d;
  logic                 idle_q, idle_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic                 bit_end;
  logic                 par_bit;
  logic                 last_stop;
  logic [DATA_BITS-1:0] shv;

  assign accept  = tx_valid && ready_q;
  assign bit_end = (cnt_q == CNT_MAX);

  // next-state: bit timer, bit index and frame sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dat_d   = dat_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          cnt_d   = '0;
          idx_d   = '0;
          dat_d   = tx_data_i;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_d = S_STOP;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == STOP_LAST) begin
            idx_d = '0;
            if (accept) begin
              state_d = S_START;
              dat_d   = tx_data_i;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // registered outputs decoded from the upcoming state
  always_comb begin
    shv       = dat_d >> idx_d;
    par_bit   = (PARITY == 1) ? ~(^dat_d) : (^dat_d);
    last_stop = (state_d == S_STOP) && (cnt_d == CNT_MAX) &&
                (idx_d == STOP_LAST);
    txd_d     = 1'b1;
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shv[0];
      S_PAR:   txd_d = par_bit;
      default: txd_d = 1'b1;
    endcase
    ready_d = (state_d == S_IDLE) || last_stop;
    done_d  = last_stop;
    idle_d  = (state_d == S_IDLE);
  end

  // state and output registers with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      dat_q   <= '0;
      txd_q   <= 1'b1;
      ready_q <= 1'b0;
      idle_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dat_q   <= dat_d;
      txd_q   <= txd_d;
      ready_q <= ready_d;
      idle_q  <= idle_d;
      done_q  <= done_d;
    end
  end

  assign txd      = txd_q;
  assign tx_ready = ready_q;
  assign tx_idle  = idle_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: four configurations of uart_tx_cfg on one clock,
// each frame checked cycle by cycle against a bit-list model.
module tb_uart_tx_cfg;

  logic       clk;
  logic       rst_n;
  logic       vld [4];
  logic [7:0] din [4];
  logic       rdy [4];
  logic       txw [4];
  logic       idl [4];
  logic       dn  [4];

  int DIVS [4] = '{4, 4, 4, 3};
  int DBS  [4] = '{8, 8, 8, 7};
  int PARS [4] = '{0, 2, 1, 0};
  int STOPS[4] = '{1, 1, 1, 2};

  int passed = 0;
  int total  = 0;

  bit         bq[$];
  logic [7:0] wq[$];

  uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .sys_clk(clk), .rst_n(rst_n), .tx_valid(vld[0]), .tx_data_i(din[0]),
    .tx_ready(rdy[0]), .txd(txw[0]), .tx_idle(idl[0]), .tx_done(dn[0]));
  uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .sys_clk(clk), .rst_n(rst_n), .tx_valid(vld[1]), .tx_data_i(din[1]),
    .tx_ready(rdy[1]), .txd(txw[1]), .tx_idle(idl[1]), .tx_done(dn[1]));
  uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
    .sys_clk(clk), .rst_n(rst_n), .tx_valid(vld[2]), .tx_data_i(din[2]),
    .tx_ready(rdy[2]), .txd(txw[2]), .tx_idle(idl[2]), .tx_done(dn[2]));
  uart_tx_cfg #(.CLK_DIV(3), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
    .sys_clk(clk), .rst_n(rst_n), .tx_valid(vld[3]),
    .tx_data_i(din[3][6:0]),
    .tx_ready(rdy[3]), .txd(txw[3]), .tx_idle(idl[3]), .tx_done(dn[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Frame as a list of line levels, one entry per bit period.
  function automatic void model(int u, logic [7:0] d);
    int ones;
    ones = 0;
    bq.delete();
    bq.push_back(1'b0);
    for (int i = 0; i < DBS[u]; i++) begin
      bq.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (PARS[u] == 2) bq.push_back(bit'(ones % 2));
    if (PARS[u] == 1) bq.push_back(bit'(1 - ones % 2));
    for (int s = 0; s < STOPS[u]; s++) bq.push_back(1'b1);
  endfunction

  task automatic run_frames(int u, bit b2b, bit scr);
    int to;
    int len;
    bit ebit;
    bit elast;
    to = 0;
    while (!rdy[u] && to < 100) begin
      tick;
      to++;
    end
    total++;
    if (rdy[u] !== 1'b1) begin
      $display("FAIL ready_wait u%0d got %b want 1", u, rdy[u]);
      return;
    end else passed++;
    for (int w = 0; w < wq.size(); w++) begin
      if (w == 0 || !b2b) begin
        vld[u] = 1'b1;
        din[u] = wq[w];
        tick;
        vld[u] = 1'b0;
      end
      model(u, wq[w]);
      len = bq.size() * DIVS[u];
      for (int c = 1; c <= len; c++) begin
        ebit  = bq[(c - 1) / DIVS[u]];
        elast = (c == len);
        total++;
        if (txw[u] !== ebit) begin
          $display("FAIL txd u%0d w%0d c%0d got %b want %b",
                   u, w, c, txw[u], ebit);
        end else passed++;
        total++;
        if (rdy[u] !== elast) begin
          $display("FAIL tx_ready u%0d w%0d c%0d got %b want %b",
                   u, w, c, rdy[u], elast);
        end else passed++;
        total++;
        if (dn[u] !== elast) begin
          $display("FAIL tx_done u%0d w%0d c%0d got %b want %b",
                   u, w, c, dn[u], elast);
        end else passed++;
        total++;
        if (idl[u] !== 1'b0) begin
          $display("FAIL tx_idle u%0d w%0d c%0d got %b want 0",
                   u, w, c, idl[u]);
        end else passed++;
        if (elast) begin
          if (b2b && w + 1 < wq.size()) begin
            vld[u] = 1'b1;
            din[u] = wq[w + 1];
          end else begin
            vld[u] = 1'b0;
          end
        end else if (scr) begin
          din[u] = 8'($urandom);
          vld[u] = 1'($urandom_range(0, 1));
        end else begin
          vld[u] = 1'b0;
        end
        tick;
      end
      if (!(b2b && w + 1 < wq.size())) begin
        total++;
        if (idl[u] !== 1'b1 || rdy[u] !== 1'b1 ||
            dn[u] !== 1'b0 || txw[u] !== 1'b1) begin
          $display("FAIL post_idle u%0d w%0d got idle%b rdy%b done%b txd%b want 1101",
                   u, w, idl[u], rdy[u], dn[u], txw[u]);
        end else passed++;
      end
    end
    vld[u] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    for (int u = 0; u < 4; u++) begin
      total++;
      if (txw[u] !== 1'b1 || rdy[u] !== 1'b0 ||
          idl[u] !== 1'b0 || dn[u] !== 1'b0) begin
        $display("FAIL reset_state u%0d got txd%b rdy%b idle%b done%b want 1000",
                 u, txw[u], rdy[u], idl[u], dn[u]);
      end else passed++;
    end
    rst_n = 1'b1;
    tick;
    for (int u = 0; u < 4; u++) begin
      total++;
      if (rdy[u] !== 1'b1 || idl[u] !== 1'b1 || txw[u] !== 1'b1) begin
        $display("FAIL reset_release u%0d got rdy%b idle%b txd%b want 111",
                 u, rdy[u], idl[u], txw[u]);
      end else passed++;
    end
  endtask

  task automatic test_8n1;
    wq = '{8'hA5};
    run_frames(0, 1'b0, 1'b0);
  endtask

  task automatic test_parity;
    wq = '{8'h07, 8'h00};
    run_frames(1, 1'b0, 1'b0);
    wq = '{8'h07};
    run_frames(2, 1'b0, 1'b0);
  endtask

  task automatic test_width_stop2;
    wq = '{8'h41, 8'hC1};
    run_frames(3, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    wq = '{8'h55, 8'hAA};
    run_frames(0, 1'b1, 1'b0);
  endtask

  task automatic test_handshake;
    wq = '{8'($urandom), 8'($urandom)};
    run_frames(0, 1'b0, 1'b1);
    wq = '{8'($urandom)};
    run_frames(1, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_frame;
    vld[0] = 1'b1;
    din[0] = 8'h37;
    tick;
    vld[0] = 1'b0;
    for (int c = 1; c < 17; c++) tick;
    total++;
    if (txw[0] !== 1'b0) begin
      $display("FAIL pre_reset_bit3 got %b want 0", txw[0]);
    end else passed++;
    rst_n = 1'b0;
    for (int r = 0; r < 2; r++) begin
      tick;
      total++;
      if (txw[0] !== 1'b1 || rdy[0] !== 1'b0 ||
          idl[0] !== 1'b0 || dn[0] !== 1'b0) begin
        $display("FAIL mid_reset r%0d got txd%b rdy%b idle%b done%b want 1000",
                 r, txw[0], rdy[0], idl[0], dn[0]);
      end else passed++;
    end
    rst_n = 1'b1;
    tick;
    total++;
    if (rdy[0] !== 1'b1 || idl[0] !== 1'b1 ||
        txw[0] !== 1'b1 || dn[0] !== 1'b0) begin
      $display("FAIL after_reset got rdy%b idle%b txd%b done%b want 1110",
               rdy[0], idl[0], txw[0], dn[0]);
    end else passed++;
    wq = '{8'hC3};
    run_frames(0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    for (int u = 0; u < 4; u++) begin
      wq = '{8'($urandom), 8'($urandom), 8'($urandom)};
      run_frames(u, 1'($urandom_range(0, 1)), 1'b1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 4; u++) begin
      vld[u] = 1'b0;
      din[u] = 8'h00;
    end
    test_reset;
    test_8n1;
    test_parity;
    test_width_stop2;
    test_back_to_back;
    test_handshake;
    test_reset_mid_frame;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 transmitter.
- Configurable data width, parity mode, stop-bit count and baud divisor.
- Owns its own bit-period counter, so frame timing starts exactly when a byte is accepted. There is no free-running baud tick.
- Valid/ready handshake on the input side; sits between a TX FIFO or RAM reader and the TXD pin.

Parameters:
CLK_DIV, 868, sys_clk cycles per UART bit (100 MHz / 115200); legal range >= 2
DATA_BITS, 8, data bits per frame, 5..9, sent LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame, 1 or 2

Ports:
sys_clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset; synchronous, active-low
tx_valid  input  1  tx_data_i holds a word to send
tx_data_i  input  DATA_BITS  word to transmit, sampled only on acceptance
tx_ready  output  1  block can accept a word this cycle
txd  output  1  UART serial line, idle high
tx_idle  output  1  no frame in progress
tx_done  output  1  one-cycle pulse marking the end of a frame

Behaviour:
- Illegal parameter values must stop elaboration with an error. Bit counter width is clog2(CLK_DIV); data index width is clog2(DATA_BITS+1).
- Reset: rst_n is sampled low on a rising edge. Next state is IDLE, txd=1, tx_ready=0, tx_idle=0, tx_done=0, all counters 0.
  - First edge with rst_n=1: tx_ready=1, tx_idle=1.
  - Reset mid-frame aborts the frame immediately. txd=1 from the next edge. No tx_done.
- All outputs are registered. There is no combinational path from tx_valid to any output.
- Acceptance occurs at edge k when tx_valid=1 and tx_ready=1 are both sampled. tx_data_i is latched into the shift register at that edge. Later changes to tx_data_i are ignored until the next acceptance.
- After edge k:
  - txd=0 (start bit), tx_ready=0, tx_idle=0.
  - Every bit, including each stop bit, holds for exactly CLK_DIV cycles.
- States and transitions:
  - IDLE -> START on acceptance.
  - START -> DATA after CLK_DIV cycles.
  - DATA shifts out bits 0..DATA_BITS-1, LSB first.
  - DATA -> PARITY if PARITY != 0, else DATA -> STOP.
  - PARITY -> STOP.
  - STOP runs STOP_BITS bit periods with txd=1, then returns to IDLE.
- Parity bit:
  - Even: XOR-reduce of the latched data.
  - Odd: inverse of that XOR-reduce.
  - Computed from the latched copy, never from tx_data_i.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLK_DIV cycles from edge k+1.
- Last cycle of the final stop bit: tx_ready=1 and tx_done=1, both for one cycle.
  - If tx_valid=1 in that cycle, the next word is accepted at that edge. txd goes straight to 0 (next start bit). tx_idle stays 0, giving zero idle gap between frames.
  - Otherwise the block enters IDLE: tx_ready=1, tx_idle=1, tx_done=0.
- tx_valid=1 while tx_ready=0 has no effect. The word is not captured; the producer holds it until accepted.
- Inside a frame, tx_idle=0 and tx_ready=0 except in the final stop cycle as above.
- Undefined state encodings recover to IDLE with txd=1 on the next edge.

Test Plan:
1. Frame timing, 8N1 (CLK_DIV=4, DATA_BITS=8, PARITY=0, STOP_BITS=1):
   - Stimulus: accept 0xA5.
   - Required txd from the next edge, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1 (40 cycles total).
   - tx_done pulses once, in cycle 40. tx_ready=0 in cycles 1..39.
2. Parity modes (CLK_DIV=4, DATA_BITS=8):
   - PARITY=2, data 0x07: parity bit 1 (bit period 10).
   - PARITY=1, data 0x07: parity bit 0.
   - PARITY=2, data 0x00: parity bit 0. Frame is 44 cycles.
3. Odd width and two stop bits (CLK_DIV=3, DATA_BITS=7, PARITY=0, STOP_BITS=2):
   - Data 0x41 gives 0,1,0,0,0,0,0,1,1,1 in 3-cycle periods (30 cycles).
   - tx_done appears only at cycle 30, not at the end of the first stop bit.
4. Back-to-back: hold tx_valid=1 with 0x55, then 0xAA.
   - Second start bit begins the cycle immediately after the first frame's last stop cycle (no extra high cycle).
   - tx_idle never rises between the frames. Exactly two tx_done pulses.
5. Handshake hygiene:
   - Change tx_data_i every cycle during a frame: the transmitted bits match the value latched at acceptance.
   - Assert tx_valid mid-frame: no capture.
6. Reset mid-frame: pull rst_n low during data bit 3 for 2 cycles.
   - txd=1 from the first reset edge; no tx_done.
   - tx_ready=0 during reset, 1 one edge after release.
   - A new acceptance then produces a clean full-length frame.
